// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with arbitrary depth, selectable standard or
// first-word-fall-through read mode, occupancy level, almost-full/empty
// thresholds, sticky overflow/underflow flags and a synchronous flush.
// Pointers are plain binary and wrap by explicit compare, so SIZE need not
// be a power of two.

module sync_fifo #(
  parameter int BITS            = 32,
  parameter int SIZE            = 16,
  parameter int FWFT            = 0,
  parameter int ALMOST_FULL_TH  = SIZE - 2,
  parameter int ALMOST_EMPTY_TH = 2,
  localparam int LW             = $clog2(SIZE + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_clear,
  input  logic            p_write_en,
  input  logic [BITS-1:0] p_write_data,
  output logic            p_write_full,
  output logic            p_write_almost_full,
  input  logic            p_read_en,
  output logic [BITS-1:0] p_read_data,
  output logic            p_read_empty,
  output logic            p_read_almost_empty,
  output logic [LW-1:0]   p_level,
  output logic            p_overflow,
  output logic            p_underflow
);

  // Pointer width covers indices 0..SIZE-1; SIZE >= 2 keeps this at least 1.
  localparam int PW = (SIZE > 1) ? $clog2(SIZE) : 1;

  localparam logic [PW-1:0] PTR_LAST = PW'(SIZE - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(SIZE);
  localparam logic [LW-1:0] LVL_AF   = LW'(ALMOST_FULL_TH);
  localparam logic [LW-1:0] LVL_AE   = LW'(ALMOST_EMPTY_TH);

  logic [BITS-1:0] mem [SIZE];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_next;
  logic [PW-1:0] rd_ptr_next;
  logic [LW-1:0] count;
  logic [LW-1:0] count_next;

  logic full;
  logic empty;
  logic write_accept;
  logic read_accept;
  logic overflow_q;
  logic underflow_q;

  // Full/empty come straight from the registered count, so no flag depends
  // combinationally on the request inputs.
  always_comb begin
    full  = (count == LVL_FULL);
    empty = (count == '0);
  end

  // Requests are accepted against the pre-cycle count; a flush swallows both.
  always_comb begin
    write_accept = p_write_en && !full  && !p_clear;
    read_accept  = p_read_en  && !empty && !p_clear;
  end

  // Pointer advance with explicit wrap from SIZE-1 back to 0.
  always_comb begin
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (write_accept) begin
      wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
    end
    if (read_accept) begin
      rd_ptr_next = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
    end
  end

  // Occupancy moves only when exactly one side is accepted.
  always_comb begin
    count_next = count;
    case ({write_accept, read_accept})
      2'b10:   count_next = count + LW'(1);
      2'b01:   count_next = count - LW'(1);
      default: count_next = count;
    endcase
  end

  // Pointer and count registers; a flush returns them to the empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (p_clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
    end
  end

  // Storage is never reset or flushed; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (write_accept) begin
      mem[wr_ptr] <= p_write_data;
    end
  end

  // Sticky error flags: any rejected request against a full/empty FIFO
  // latches until reset or flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (p_clear) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (p_write_en && full) begin
        overflow_q <= 1'b1;
      end
      if (p_read_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  generate
    if (FWFT == 0) begin : g_std_read
      logic [BITS-1:0] rd_data_q;

      // Standard mode: the head word is captured on the edge that accepts
      // the read and held until the next accepted read or flush.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q <= '0;
        end else if (p_clear) begin
          rd_data_q <= '0;
        end else if (read_accept) begin
          rd_data_q <= mem[rd_ptr];
        end
      end

      assign p_read_data = rd_data_q;
    end else begin : g_fwft_read
      // FWFT mode: the head word is always presented, zero while empty.
      always_comb begin
        p_read_data = '0;
        if (!empty) begin
          p_read_data = mem[rd_ptr];
        end
      end
    end
  endgenerate

  assign p_write_full        = full;
  assign p_write_almost_full = (count >= LVL_AF);
  assign p_read_empty        = empty;
  assign p_read_almost_empty = (count <= LVL_AE);
  assign p_level             = count;
  assign p_overflow          = overflow_q;
  assign p_underflow         = underflow_q;

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: drives a SIZE=5 standard-mode FIFO (unit 0) and a SIZE=4
// FWFT FIFO (unit 1) with directed vectors. A queue-style model (head at
// index 0, shifted on pop) predicts every output and is compared each cycle;
// hand-computed literal expectations pin the model at key points.

module tb_sync_fifo;

  logic clk;
  logic rst;

  logic       we  [2];
  logic [7:0] wd  [2];
  logic       re  [2];
  logic       clr [2];

  logic [2:0] lvl0, lvl1;
  logic [7:0] data0, data1;
  logic full0, full1, af0, af1, empty0, empty1, ae0, ae1;
  logic ovf0, ovf1, unf0, unf1;

  int nChecks = 0;
  int nFails  = 0;

  sync_fifo #(.BITS(8), .SIZE(5), .FWFT(0)) dut_std (
    .clk                 (clk),
    .rst                 (rst),
    .p_clear             (clr[0]),
    .p_write_en          (we[0]),
    .p_write_data        (wd[0]),
    .p_write_full        (full0),
    .p_write_almost_full (af0),
    .p_read_en           (re[0]),
    .p_read_data         (data0),
    .p_read_empty        (empty0),
    .p_read_almost_empty (ae0),
    .p_level             (lvl0),
    .p_overflow          (ovf0),
    .p_underflow         (unf0)
  );

  sync_fifo #(.BITS(8), .SIZE(4), .FWFT(1)) dut_fwft (
    .clk                 (clk),
    .rst                 (rst),
    .p_clear             (clr[1]),
    .p_write_en          (we[1]),
    .p_write_data        (wd[1]),
    .p_write_full        (full1),
    .p_write_almost_full (af1),
    .p_read_en           (re[1]),
    .p_read_data         (data1),
    .p_read_empty        (empty1),
    .p_read_almost_empty (ae1),
    .p_level             (lvl1),
    .p_overflow          (ovf1),
    .p_underflow         (unf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: entries held head-first, plus sticky flags and the
  // standard-mode output register.
  logic [7:0] mq [2][8];
  int         mcnt [2];
  logic       mov  [2];
  logic       mun  [2];
  logic [7:0] mrd  [2];
  int         msz  [2] = '{5, 4};
  int         maf  [2] = '{3, 2};
  int         mae  [2] = '{2, 2};
  bit         mfw  [2] = '{1'b0, 1'b1};

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      mov[k]  = 1'b0;
      mun[k]  = 1'b0;
      mrd[k]  = 8'h00;
    end
  endtask

  task automatic modelStep(input int k);
    bit isFull, isEmpty, wAcc, rAcc;
    if (clr[k]) begin
      mcnt[k] = 0;
      mov[k]  = 1'b0;
      mun[k]  = 1'b0;
      mrd[k]  = 8'h00;
    end else begin
      isFull  = (mcnt[k] == msz[k]);
      isEmpty = (mcnt[k] == 0);
      wAcc    = we[k] && !isFull;
      rAcc    = re[k] && !isEmpty;
      if (we[k] && isFull) mov[k] = 1'b1;
      if (re[k] && isEmpty) mun[k] = 1'b1;
      if (rAcc) begin
        mrd[k] = mq[k][0];
        for (int i = 0; i < 7; i++) mq[k][i] = mq[k][i+1];
        mcnt[k] = mcnt[k] - 1;
      end
      if (wAcc) begin
        mq[k][mcnt[k]] = wd[k];
        mcnt[k] = mcnt[k] + 1;
      end
    end
  endtask

  // Model advances on the same edges as the DUTs, including async reset.
  always @(posedge clk or posedge rst) begin
    if (rst) modelReset();
    else begin
      modelStep(0);
      modelStep(1);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkDut(input int k, input logic [2:0] lvl, input logic emp, input logic aemp,
                          input logic ful, input logic aful, input logic [7:0] dat,
                          input logic ov, input logic un);
    logic [7:0] expData;
    expData = mfw[k] ? ((mcnt[k] == 0) ? 8'h00 : mq[k][0]) : mrd[k];
    checkOutput($sformatf("model_level%0d", k),  {29'd0, lvl}, mcnt[k]);
    checkOutput($sformatf("model_empty%0d", k),  {31'd0, emp}, mcnt[k] == 0);
    checkOutput($sformatf("model_aempty%0d", k), {31'd0, aemp}, mcnt[k] <= mae[k]);
    checkOutput($sformatf("model_full%0d", k),   {31'd0, ful}, mcnt[k] == msz[k]);
    checkOutput($sformatf("model_afull%0d", k),  {31'd0, aful}, mcnt[k] >= maf[k]);
    checkOutput($sformatf("model_data%0d", k),   {24'd0, dat}, {24'd0, expData});
    checkOutput($sformatf("model_ovf%0d", k),    {31'd0, ov}, {31'd0, mov[k]});
    checkOutput($sformatf("model_unf%0d", k),    {31'd0, un}, {31'd0, mun[k]});
  endtask

  // Every cycle outside reset, both units are compared against the model.
  always @(negedge clk) begin
    if (!rst) begin
      checkDut(0, lvl0, empty0, ae0, full0, af0, data0, ovf0, unf0);
      checkDut(1, lvl1, empty1, ae1, full1, af1, data1, ovf1, unf1);
    end
  end

  task automatic applyStimulus(input int k, input logic w, input logic [7:0] d,
                               input logic r, input logic c);
    we[k]  = w;
    wd[k]  = d;
    re[k]  = r;
    clr[k] = c;
    @(negedge clk);
    we[k]  = 1'b0;
    re[k]  = 1'b0;
    clr[k] = 1'b0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_level0", {29'd0, lvl0}, 0);
    checkOutput("rst_empty0", {31'd0, empty0}, 1);
    checkOutput("rst_aempty0", {31'd0, ae0}, 1);
    checkOutput("rst_full0", {31'd0, full0}, 0);
    checkOutput("rst_afull0", {31'd0, af0}, 0);
    checkOutput("rst_data0", {24'd0, data0}, 0);
    checkOutput("rst_ovf0", {31'd0, ovf0}, 0);
    checkOutput("rst_unf0", {31'd0, unf0}, 0);
    checkOutput("rst_level1", {29'd0, lvl1}, 0);
    checkOutput("rst_empty1", {31'd0, empty1}, 1);
    checkOutput("rst_data1", {24'd0, data1}, 0);
    checkOutput("rst_ovf1", {31'd0, ovf1}, 0);
    checkOutput("rst_unf1", {31'd0, unf1}, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      we[k] = 1'b0; wd[k] = 8'h00; re[k] = 1'b0; clr[k] = 1'b0;
    end
    #2;
    checkResetValues();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Fill the SIZE=5 standard unit with 0x11..0x55.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b1, 8'(8'h11 * (i + 1)), 1'b0, 1'b0);
      checkOutput("fill_level", {29'd0, lvl0}, i + 1);
      checkOutput("fill_afull", {31'd0, af0}, (i + 1) >= 3);
      checkOutput("fill_full", {31'd0, full0}, i == 4);
    end
    applyStimulus(0, 1'b1, 8'h66, 1'b0, 1'b0);
    checkOutput("drop_level", {29'd0, lvl0}, 5);
    checkOutput("drop_ovf", {31'd0, ovf0}, 1);

    // Drain in order; the dropped 0x66 must not appear.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput("drain_data", {24'd0, data0}, 8'(8'h11 * (i + 1)));
      checkOutput("drain_empty", {31'd0, empty0}, i == 4);
    end
    checkOutput("drain_unf", {31'd0, unf0}, 0);

    // Twelve more words through a one-deep pipeline: pointers wrap twice.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1'b1, 8'(8'hA0 + i), i > 0, 1'b0);
      if (i > 0) checkOutput("wrap_data", {24'd0, data0}, 8'(8'hA0 + i - 1));
      checkOutput("wrap_level", {29'd0, lvl0}, 1);
    end
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("wrap_last", {24'd0, data0}, 8'hAB);
    checkOutput("wrap_empty", {31'd0, empty0}, 1);

    // Flush at level 3 with a concurrent write on the standard unit.
    applyStimulus(0, 1'b1, 8'h31, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 8'h32, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(0, 1'b1, 8'hCC, 1'b0, 1'b1);
    checkOutput("clr0_level", {29'd0, lvl0}, 0);
    checkOutput("clr0_empty", {31'd0, empty0}, 1);
    checkOutput("clr0_data", {24'd0, data0}, 0);
    checkOutput("clr0_ovf", {31'd0, ovf0}, 0);
    applyStimulus(0, 1'b1, 8'h44, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("clr0_after", {24'd0, data0}, 8'h44);

    // FWFT: a word written into the empty unit shows up without a read.
    applyStimulus(1, 1'b1, 8'hA5, 1'b0, 1'b0);
    checkOutput("fwft_empty", {31'd0, empty1}, 0);
    checkOutput("fwft_show", {24'd0, data1}, 8'hA5);
    applyStimulus(1, 1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("fwft_hold", {24'd0, data1}, 8'hA5);
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("fwft_pop_data", {24'd0, data1}, 0);
    checkOutput("fwft_pop_empty", {31'd0, empty1}, 1);

    // Full with write+read: read wins, 0x77 is rejected.
    for (int i = 0; i < 4; i++) applyStimulus(1, 1'b1, 8'(i + 1), 1'b0, 1'b0);
    checkOutput("s4_full", {31'd0, full1}, 1);
    applyStimulus(1, 1'b1, 8'h77, 1'b1, 1'b0);
    checkOutput("s4_full_level", {29'd0, lvl1}, 3);
    checkOutput("s4_full_ovf", {31'd0, ovf1}, 1);
    checkOutput("s4_full_head", {24'd0, data1}, 8'h02);
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("s4_head3", {24'd0, data1}, 8'h03);
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("s4_head4", {24'd0, data1}, 8'h04);
    applyStimulus(1, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("s4_no77", {24'd0, data1}, 0);
    checkOutput("s4_no77_level", {29'd0, lvl1}, 0);

    // Empty with write+read: write wins, underflow latches.
    applyStimulus(1, 1'b1, 8'h88, 1'b1, 1'b0);
    checkOutput("s4_empty_level", {29'd0, lvl1}, 1);
    checkOutput("s4_empty_unf", {31'd0, unf1}, 1);
    checkOutput("s4_empty_data", {24'd0, data1}, 8'h88);
    applyStimulus(1, 1'b1, 8'h99, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 8'hAA, 1'b1, 1'b0);
    checkOutput("s4_mid_level", {29'd0, lvl1}, 2);
    checkOutput("s4_mid_head", {24'd0, data1}, 8'h99);

    // Flush at level 3 with a concurrent write on the FWFT unit.
    applyStimulus(1, 1'b1, 8'hBB, 1'b0, 1'b0);
    applyStimulus(1, 1'b1, 8'hCC, 1'b0, 1'b1);
    checkOutput("clr1_level", {29'd0, lvl1}, 0);
    checkOutput("clr1_empty", {31'd0, empty1}, 1);
    checkOutput("clr1_ovf", {31'd0, ovf1}, 0);
    checkOutput("clr1_unf", {31'd0, unf1}, 0);
    applyStimulus(1, 1'b1, 8'hDD, 1'b0, 1'b0);
    checkOutput("clr1_after_level", {29'd0, lvl1}, 1);
    checkOutput("clr1_after_data", {24'd0, data1}, 8'hDD);

    // Asynchronous reset between edges during a write burst.
    we[0] = 1'b1;
    wd[0] = 8'h21;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 checkResetValues();
    we[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 1'b1, 8'h5A, 1'b0, 1'b0);
    applyStimulus(0, 1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("arst_data", {24'd0, data0}, 8'h5A);
    checkOutput("arst_empty", {31'd0, empty0}, 1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFails);
    $finish;
  end

endmodule
